// File: rtl/Types.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : Types                                                      |
// | Description : Shared types and widths for the writeback stage: datapath  |
// |               and register-index widths, the writeback FSM state enum    |
// |               and the in-flight destination tag record.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package Types;

  localparam int DATA      = 32;
  localparam int REG_WIDTH = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic                 valid;
    logic [REG_WIDTH-1:0] rd;
  } wb_tag_t;

endpackage
`default_nettype wire

// File: rtl/dest_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dest_tracker                                               |
// | Description : Two-slot shift register of in-flight destination tags used |
// |               by decode for hazard comparison. Slot 0 is the youngest.   |
// | Ports       : clock, rst (async active-low)                              |
// |               shift_en        - 1 = accept issue, 0 = shift bubbles only |
// |               issue_valid/issue_regwrite/issue_rd - issued instruction   |
// |               flush           - squash the tag entering slot 0           |
// |               vld[1:0], rd0, rd1 - slot contents                         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module dest_tracker
  import Types::*;
(
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 shift_en,
  input  logic                 issue_valid,
  input  logic                 issue_regwrite,
  input  logic [REG_WIDTH-1:0] issue_rd,
  input  logic                 flush,
  output logic [1:0]           vld,
  output logic [REG_WIDTH-1:0] rd0,
  output logic [REG_WIDTH-1:0] rd1
);

  wb_tag_t r_slot0;
  wb_tag_t r_slot1;
  wb_tag_t w_next;

  // A stalled issue still carries its index but is marked invalid; a flush or
  // a non-running stage inserts a clean bubble. x0 writes never create hazards.
  always_comb begin
    w_next.valid = 1'b0;
    w_next.rd    = '0;
    if (shift_en && !flush) begin
      w_next.valid = issue_valid && issue_regwrite && (issue_rd != '0);
      w_next.rd    = issue_rd;
    end
  end

  // Slot 1 always takes the previous slot 0, even on flush: only the youngest
  // tag belongs to the squashed path.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else begin
      r_slot1 <= r_slot0;
      r_slot0 <= w_next;
    end
  end

  assign vld = {r_slot1.valid, r_slot0.valid};
  assign rd0 = r_slot0.rd;
  assign rd1 = r_slot1.rd;

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : writeback_stage                                            |
// | Description : Pipeline writeback: registered register-file write port,   |
// |               in-flight destination tags, HALT drain FSM and optional    |
// |               retirement statistics.                                     |
// | Config      : WB_STATS_EN - when defined, retired_count/regwrite_count   |
// |               are saturating counters; otherwise they read 0.            |
// | Ports       : clock, rst (async active-low)                              |
// |               mem_*   - MEM/WB slot (valid, regwrite, wbmux, rd, data)   |
// |               issue_* - decode issue info; flush squashes youngest tag   |
// |               wr_en/wr_addr/wr_data - register-file write port           |
// |               inflight_vld/rd0/rd1  - in-flight tags (slot 0 youngest)   |
// |               halted, retired_count, regwrite_count                      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module writeback_stage #(
  parameter int DATA      = Types::DATA,
  parameter int REG_WIDTH = Types::REG_WIDTH
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 mem_valid,
  input  logic                 mem_regwrite,
  input  logic                 mem_wbmux,
  input  logic [REG_WIDTH-1:0] mem_rd,
  input  logic [DATA-1:0]      mem_alu_result,
  input  logic [DATA-1:0]      mem_load_data,
  input  logic                 mem_halt,
  input  logic                 issue_valid,
  input  logic                 issue_regwrite,
  input  logic [REG_WIDTH-1:0] issue_rd,
  input  logic                 flush,
  output logic                 wr_en,
  output logic [REG_WIDTH-1:0] wr_addr,
  output logic [DATA-1:0]      wr_data,
  output logic [1:0]           inflight_vld,
  output logic [REG_WIDTH-1:0] inflight_rd0,
  output logic [REG_WIDTH-1:0] inflight_rd1,
  output logic                 halted,
  output logic [31:0]          retired_count,
  output logic [31:0]          regwrite_count
);

  import Types::*;

  wb_state_e            r_state;
  logic                 r_wr_en;
  logic [REG_WIDTH-1:0] r_wr_addr;
  logic [DATA-1:0]      r_wr_data;
  logic                 r_halted;

  logic w_run;
  logic w_write;

  assign w_run   = (r_state == RUN);
  // HALT never writes, even if it carries regwrite; x0 is never written.
  assign w_write = w_run && mem_valid && mem_regwrite && !mem_halt && (mem_rd != '0);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state   <= RUN;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_wr_en <= w_write;
          // Address/data hold their last value while no write is issued.
          if (w_write) begin
            r_wr_addr <= mem_rd;
            r_wr_data <= mem_wbmux ? mem_alu_result : mem_load_data;
          end
          if (mem_valid && mem_halt) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_wr_en  <= 1'b0;
          r_state  <= HALTED;
          r_halted <= 1'b1;
        end
        HALTED: begin
          r_wr_en  <= 1'b0;
          r_halted <= 1'b1;
        end
        default: begin
          r_wr_en  <= 1'b0;
          r_state  <= RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign halted  = r_halted;

  dest_tracker u_dest_tracker (
    .clock          (clock),
    .rst            (rst),
    .shift_en       (w_run),
    .issue_valid    (issue_valid),
    .issue_regwrite (issue_regwrite),
    .issue_rd       (issue_rd),
    .flush          (flush),
    .vld            (inflight_vld),
    .rd0            (inflight_rd0),
    .rd1            (inflight_rd1)
  );

`ifdef WB_STATS_EN
  logic [31:0] r_retired_count;
  logic [31:0] r_regwrite_count;

  // Counters only update when they advance so they hold at all-ones.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_retired_count  <= '0;
      r_regwrite_count <= '0;
    end else begin
      if (w_run && mem_valid && (r_retired_count != 32'hFFFF_FFFF)) begin
        r_retired_count <= r_retired_count + 32'd1;
      end
      if (w_write && (r_regwrite_count != 32'hFFFF_FFFF)) begin
        r_regwrite_count <= r_regwrite_count + 32'd1;
      end
    end
  end

  assign retired_count  = r_retired_count;
  assign regwrite_count = r_regwrite_count;
`else
  assign retired_count  = 32'd0;
  assign regwrite_count = 32'd0;
`endif

endmodule
`default_nettype wire
